// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared widths, FSM states and owner IDs for the memory port arbiter
package memory_port_arbiter_pkg;
  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_INS  = 1'b0,
    ARB_OWNER_DATA = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// rtl/memory_port_arbiter_if.sv - fetch, load/store and memory-side signals of the arbiter
interface memory_port_arbiter_if;
  import memory_port_arbiter_pkg::*;

  logic              i_Ins_Req_Valid;
  logic              o_Ins_Req_Ready;
  logic [XLEN-1:0]   i_Ins_Addr;
  logic              o_Ins_Resp_Valid;
  logic [XLEN-1:0]   o_Ins_Resp_Data;

  logic              i_Data_Req_Valid;
  logic              o_Data_Req_Ready;
  logic [XLEN-1:0]   i_Data_Addr;
  logic              i_Data_Write_Enable;
  logic [XLEN-1:0]   i_Data_Write_Data;
  logic [STRB_W-1:0] i_Data_Byte_Enable;
  logic              o_Data_Resp_Valid;
  logic [XLEN-1:0]   o_Data_Resp_Data;

  logic              o_Mem_Req_Valid;
  logic              i_Mem_Req_Ready;
  logic [XLEN-1:0]   o_Mem_Addr;
  logic [XLEN-1:0]   o_Mem_Write_Data;
  logic              o_Mem_Write_Enable;
  logic [STRB_W-1:0] o_Mem_Byte_Enable;
  logic              i_Mem_Resp_Valid;
  logic [XLEN-1:0]   i_Mem_Resp_Data;
  logic              o_Busy;

  modport slave (
    input  i_Ins_Req_Valid, i_Ins_Addr,
    output o_Ins_Req_Ready, o_Ins_Resp_Valid, o_Ins_Resp_Data,
    input  i_Data_Req_Valid, i_Data_Addr, i_Data_Write_Enable, i_Data_Write_Data, i_Data_Byte_Enable,
    output o_Data_Req_Ready, o_Data_Resp_Valid, o_Data_Resp_Data,
    output o_Mem_Req_Valid, o_Mem_Addr, o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Byte_Enable,
    input  i_Mem_Req_Ready, i_Mem_Resp_Valid, i_Mem_Resp_Data,
    output o_Busy
  );

  modport master (
    output i_Ins_Req_Valid, i_Ins_Addr,
    input  o_Ins_Req_Ready, o_Ins_Resp_Valid, o_Ins_Resp_Data,
    output i_Data_Req_Valid, i_Data_Addr, i_Data_Write_Enable, i_Data_Write_Data, i_Data_Byte_Enable,
    input  o_Data_Req_Ready, o_Data_Resp_Valid, o_Data_Resp_Data,
    input  o_Mem_Req_Valid, o_Mem_Addr, o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Byte_Enable,
    output i_Mem_Req_Ready, i_Mem_Resp_Valid, i_Mem_Resp_Data,
    input  o_Busy
  );
endinterface

// File: rtl/memory_port_arbiter_round_robin_picker_2.sv
// rtl/memory_port_arbiter_round_robin_picker_2.sv - two-way round-robin grant, bit 0 = fetch, bit 1 = load/store
module round_robin_picker_2
  import memory_port_arbiter_pkg::*;
(
  input  logic       ins_valid,
  input  logic       data_valid,
  input  arb_owner_t last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (ins_valid && data_valid) begin
      grant = (last_grant == ARB_OWNER_DATA) ? 2'b01 : 2'b10;
    end else if (ins_valid) begin
      grant = 2'b01;
    end else if (data_valid) begin
      grant = 2'b10;
    end
  end
endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one memory port between fetch and load/store, one transaction in flight
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
(
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  memory_port_arbiter_if.slave  bus
);
  arb_state_t        r_State;
  arb_owner_t        r_Last_Grant;
  arb_owner_t        r_Owner;
  logic              r_Mem_Req_Valid;
  logic [XLEN-1:0]   r_Mem_Addr;
  logic [XLEN-1:0]   r_Mem_Write_Data;
  logic              r_Mem_Write_Enable;
  logic [STRB_W-1:0] r_Mem_Byte_Enable;
  logic              r_Ins_Resp_Valid;
  logic [XLEN-1:0]   r_Ins_Resp_Data;
  logic              r_Data_Resp_Valid;
  logic [XLEN-1:0]   r_Data_Resp_Data;
  logic [1:0]        grant;
  logic              ins_fire;
  logic              data_fire;

  round_robin_picker_2 u_picker (
    .ins_valid  (bus.i_Ins_Req_Valid),
    .data_valid (bus.i_Data_Req_Valid),
    .last_grant (r_Last_Grant),
    .grant      (grant)
  );

  // Ready is only offered from IDLE and never while reset is being applied.
  assign bus.o_Ins_Req_Ready  = (r_State == ARB_IDLE) && !i_Reset && grant[0];
  assign bus.o_Data_Req_Ready = (r_State == ARB_IDLE) && !i_Reset && grant[1];
  assign ins_fire  = bus.i_Ins_Req_Valid  && bus.o_Ins_Req_Ready;
  assign data_fire = bus.i_Data_Req_Valid && bus.o_Data_Req_Ready;

  assign bus.o_Mem_Req_Valid    = r_Mem_Req_Valid;
  assign bus.o_Mem_Addr         = r_Mem_Addr;
  assign bus.o_Mem_Write_Data   = r_Mem_Write_Data;
  assign bus.o_Mem_Write_Enable = r_Mem_Write_Enable;
  assign bus.o_Mem_Byte_Enable  = r_Mem_Byte_Enable;
  assign bus.o_Ins_Resp_Valid   = r_Ins_Resp_Valid;
  assign bus.o_Ins_Resp_Data    = r_Ins_Resp_Data;
  assign bus.o_Data_Resp_Valid  = r_Data_Resp_Valid;
  assign bus.o_Data_Resp_Data   = r_Data_Resp_Data;
  assign bus.o_Busy             = (r_State != ARB_IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State            <= ARB_IDLE;
      r_Last_Grant       <= ARB_OWNER_DATA;
      r_Owner            <= ARB_OWNER_INS;
      r_Mem_Req_Valid    <= 1'b0;
      r_Mem_Addr         <= '0;
      r_Mem_Write_Data   <= '0;
      r_Mem_Write_Enable <= 1'b0;
      r_Mem_Byte_Enable  <= '0;
      r_Ins_Resp_Valid   <= 1'b0;
      r_Ins_Resp_Data    <= '0;
      r_Data_Resp_Valid  <= 1'b0;
      r_Data_Resp_Data   <= '0;
    end else begin
      r_Ins_Resp_Valid  <= 1'b0;
      r_Data_Resp_Valid <= 1'b0;
      case (r_State)
        ARB_IDLE: begin
          if (ins_fire) begin
            r_Mem_Addr         <= bus.i_Ins_Addr;
            r_Mem_Write_Data   <= '0;
            r_Mem_Write_Enable <= 1'b0;
            r_Mem_Byte_Enable  <= '1;
            r_Owner            <= ARB_OWNER_INS;
            r_Last_Grant       <= ARB_OWNER_INS;
            r_Mem_Req_Valid    <= 1'b1;
            r_State            <= ARB_ISSUE;
          end else if (data_fire) begin
            r_Mem_Addr         <= bus.i_Data_Addr;
            r_Mem_Write_Data   <= bus.i_Data_Write_Data;
            r_Mem_Write_Enable <= bus.i_Data_Write_Enable;
            r_Mem_Byte_Enable  <= bus.i_Data_Byte_Enable;
            r_Owner            <= ARB_OWNER_DATA;
            r_Last_Grant       <= ARB_OWNER_DATA;
            r_Mem_Req_Valid    <= 1'b1;
            r_State            <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.i_Mem_Req_Ready) begin
            r_Mem_Req_Valid <= 1'b0;
            r_State         <= ARB_WAIT_RESP;
          end
        end
        ARB_WAIT_RESP: begin
          if (bus.i_Mem_Resp_Valid) begin
            if (r_Owner == ARB_OWNER_INS) begin
              r_Ins_Resp_Data  <= bus.i_Mem_Resp_Data;
              r_Ins_Resp_Valid <= 1'b1;
            end else begin
              // Stores acknowledge with zero data regardless of what the bus returns.
              r_Data_Resp_Data  <= r_Mem_Write_Enable ? '0 : bus.i_Mem_Resp_Data;
              r_Data_Resp_Valid <= 1'b1;
            end
            r_State <= ARB_IDLE;
          end
        end
        default: r_State <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed scoreboard bench for memory_port_arbiter
module tb_memory_port_arbiter;
  import memory_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_port_arbiter_if bus();

  memory_port_arbiter dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    arb_owner_t      owner;
    logic [XLEN-1:0] data;
  } resp_t;

  resp_t sb[$];
  resp_t mon_r;
  int total = 0;
  int bad = 0;
  int resp_count = 0;

  int                w;
  logic [XLEN-1:0]   a;
  logic              we;
  logic [XLEN-1:0]   wd;
  logic [STRB_W-1:0] be;
  int                cnt0;
  logic [XLEN-1:0]   tie_data [4];

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input arb_owner_t o, input logic [XLEN-1:0] d);
    resp_t r;
    r.owner = o;
    r.data  = d;
    sb.push_back(r);
  endtask

  // Memory side of one transaction: optional accept stall, then optional response delay.
  task automatic serve(input int ready_delay, input int resp_delay, input logic [XLEN-1:0] rdata,
                       output int wc, output logic [XLEN-1:0] ca, output logic cwe,
                       output logic [XLEN-1:0] cwd, output logic [STRB_W-1:0] cbe);
    wc = 0;
    while (bus.o_Mem_Req_Valid !== 1'b1 && wc < 20) begin
      step();
      wc++;
    end
    chk("mem_req_seen", XLEN'(bus.o_Mem_Req_Valid), 1);
    ca  = bus.o_Mem_Addr;
    cwe = bus.o_Mem_Write_Enable;
    cwd = bus.o_Mem_Write_Data;
    cbe = bus.o_Mem_Byte_Enable;
    repeat (ready_delay) begin
      @(negedge clk);
      chk("stall_req_valid", XLEN'(bus.o_Mem_Req_Valid), 1);
      chk("stall_addr", bus.o_Mem_Addr, ca);
      chk("stall_be", XLEN'(bus.o_Mem_Byte_Enable), XLEN'(cbe));
      chk("stall_busy", XLEN'(bus.o_Busy), 1);
      chk("stall_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 0);
      chk("stall_data_ready", XLEN'(bus.o_Data_Req_Ready), 0);
      step();
    end
    bus.i_Mem_Req_Ready = 1'b1;
    step();
    bus.i_Mem_Req_Ready = 1'b0;
    repeat (resp_delay) begin
      @(negedge clk);
      chk("wait_busy", XLEN'(bus.o_Busy), 1);
      chk("wait_req_valid", XLEN'(bus.o_Mem_Req_Valid), 0);
      chk("wait_data_ready", XLEN'(bus.o_Data_Req_Ready), 0);
      step();
    end
    bus.i_Mem_Resp_Data  = rdata;
    bus.i_Mem_Resp_Valid = 1'b1;
    step();
    bus.i_Mem_Resp_Valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.o_Ins_Resp_Valid === 1'b1 || bus.o_Data_Resp_Valid === 1'b1) begin
      resp_count++;
      chk("resp_onehot", XLEN'(bus.o_Ins_Resp_Valid & bus.o_Data_Resp_Valid), 0);
      if (sb.size() == 0) begin
        chk("resp_unexpected", XLEN'(sb.size()), 1);
      end else begin
        mon_r = sb.pop_front();
        chk("resp_owner", XLEN'(bus.o_Data_Resp_Valid), XLEN'(mon_r.owner == ARB_OWNER_DATA));
        chk("resp_data", bus.o_Data_Resp_Valid ? bus.o_Data_Resp_Data : bus.o_Ins_Resp_Data, mon_r.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Ins_Req_Valid = 0; bus.i_Ins_Addr = '0;
    bus.i_Data_Req_Valid = 0; bus.i_Data_Addr = '0; bus.i_Data_Write_Enable = 0;
    bus.i_Data_Write_Data = '0; bus.i_Data_Byte_Enable = '0;
    bus.i_Mem_Req_Ready = 0; bus.i_Mem_Resp_Valid = 0; bus.i_Mem_Resp_Data = '0;
    tie_data[0] = 32'h1111_0000; tie_data[1] = 32'h2222_0000;
    tie_data[2] = 32'h3333_0000; tie_data[3] = 32'h4444_0000;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_busy", XLEN'(bus.o_Busy), 0);
    chk("rst_req_valid", XLEN'(bus.o_Mem_Req_Valid), 0);
    chk("rst_addr", bus.o_Mem_Addr, 0);
    chk("rst_be", XLEN'(bus.o_Mem_Byte_Enable), 0);
    chk("rst_ins_resp", XLEN'(bus.o_Ins_Resp_Valid), 0);
    chk("rst_data_resp_data", bus.o_Data_Resp_Data, 0);
    chk("rst_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 0);
    rst = 1'b0;
    step();

    // Fetch after reset, minimum latency
    bus.i_Ins_Req_Valid = 1; bus.i_Ins_Addr = 32'h100;
    @(negedge clk);
    chk("f_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 1);
    chk("f_data_ready", XLEN'(bus.o_Data_Req_Ready), 0);
    expect_resp(ARB_OWNER_INS, 32'hDEAD_BEEF);
    step();
    bus.i_Ins_Req_Valid = 0;
    serve(0, 0, 32'hDEAD_BEEF, w, a, we, wd, be);
    chk("f_req_latency", XLEN'(w), 0);
    chk("f_addr", a, 32'h100);
    chk("f_be", XLEN'(be), 32'hF);
    chk("f_we", XLEN'(we), 0);
    chk("f_ins_resp_valid", XLEN'(bus.o_Ins_Resp_Valid), 1);
    chk("f_data_resp_valid", XLEN'(bus.o_Data_Resp_Valid), 0);
    chk("f_ins_resp_data", bus.o_Ins_Resp_Data, 32'hDEAD_BEEF);
    step();
    chk("f_pulse_one_cycle", XLEN'(bus.o_Ins_Resp_Valid), 0);

    // Tie resolution with both requesters held valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_Ins_Req_Valid = 1; bus.i_Ins_Addr = 32'h200;
    bus.i_Data_Req_Valid = 1; bus.i_Data_Addr = 32'h300; bus.i_Data_Write_Enable = 0;
    bus.i_Data_Write_Data = 32'hAAAA_AAAA; bus.i_Data_Byte_Enable = 4'hF;
    expect_resp(ARB_OWNER_INS, tie_data[0]);
    expect_resp(ARB_OWNER_DATA, tie_data[1]);
    expect_resp(ARB_OWNER_INS, tie_data[2]);
    expect_resp(ARB_OWNER_DATA, tie_data[3]);
    @(negedge clk);
    chk("tie_first_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 1);
    chk("tie_first_data_ready", XLEN'(bus.o_Data_Req_Ready), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, tie_data[i], w, a, we, wd, be);
      chk("tie_addr", a, (i % 2 == 1) ? 32'h300 : 32'h200);
      if (i < 3) begin
        chk("tie_next_ins_ready", XLEN'(bus.o_Ins_Req_Ready), (i % 2 == 1) ? 1 : 0);
        chk("tie_next_data_ready", XLEN'(bus.o_Data_Req_Ready), (i % 2 == 0) ? 1 : 0);
      end else begin
        bus.i_Ins_Req_Valid = 0;
        bus.i_Data_Req_Valid = 0;
      end
      step();
    end

    // Store
    bus.i_Data_Req_Valid = 1; bus.i_Data_Addr = 32'h20; bus.i_Data_Write_Enable = 1;
    bus.i_Data_Write_Data = 32'h1234_5678; bus.i_Data_Byte_Enable = 4'h3;
    @(negedge clk);
    chk("st_data_ready", XLEN'(bus.o_Data_Req_Ready), 1);
    expect_resp(ARB_OWNER_DATA, 32'h0);
    step();
    bus.i_Data_Req_Valid = 0;
    serve(0, 0, 32'hFFFF_FFFF, w, a, we, wd, be);
    chk("st_we", XLEN'(we), 1);
    chk("st_addr", a, 32'h20);
    chk("st_wdata", wd, 32'h1234_5678);
    chk("st_be", XLEN'(be), 32'h3);
    chk("st_resp_valid", XLEN'(bus.o_Data_Resp_Valid), 1);
    chk("st_resp_data", bus.o_Data_Resp_Data, 0);
    step();

    // Back-pressure with a competing load held pending
    bus.i_Ins_Req_Valid = 1; bus.i_Ins_Addr = 32'h400;
    @(negedge clk);
    chk("bp_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 1);
    expect_resp(ARB_OWNER_INS, 32'h0BAD_F00D);
    step();
    bus.i_Ins_Req_Valid = 0;
    bus.i_Data_Req_Valid = 1; bus.i_Data_Addr = 32'h44; bus.i_Data_Write_Enable = 0;
    cnt0 = resp_count;
    serve(5, 4, 32'h0BAD_F00D, w, a, we, wd, be);
    bus.i_Data_Req_Valid = 0;
    chk("bp_addr", a, 32'h400);
    chk("bp_resp_valid", XLEN'(bus.o_Ins_Resp_Valid), 1);
    step();
    step();
    chk("bp_one_pulse", XLEN'(resp_count - cnt0), 1);
    chk("bp_idle", XLEN'(bus.o_Busy), 0);

    // Reset in WAIT_RESP, response during and after reset
    bus.i_Ins_Req_Valid = 1; bus.i_Ins_Addr = 32'h500;
    @(negedge clk);
    chk("rm_ins_ready", XLEN'(bus.o_Ins_Req_Ready), 1);
    step();
    bus.i_Ins_Req_Valid = 0;
    bus.i_Mem_Req_Ready = 1;
    step();
    bus.i_Mem_Req_Ready = 0;
    @(negedge clk);
    chk("rm_wait_busy", XLEN'(bus.o_Busy), 1);
    cnt0 = resp_count;
    rst = 1'b1;
    bus.i_Mem_Resp_Valid = 1; bus.i_Mem_Resp_Data = 32'hBADB_AD00;
    step();
    rst = 1'b0;
    step();
    bus.i_Mem_Resp_Valid = 0;
    @(negedge clk);
    chk("rm_busy", XLEN'(bus.o_Busy), 0);
    chk("rm_req_valid", XLEN'(bus.o_Mem_Req_Valid), 0);
    chk("rm_no_pulse", XLEN'(resp_count - cnt0), 0);
    step();
    bus.i_Ins_Req_Valid = 1; bus.i_Ins_Addr = 32'h600;
    expect_resp(ARB_OWNER_INS, 32'h6600_AA55);
    @(negedge clk);
    chk("rm_fresh_ready", XLEN'(bus.o_Ins_Req_Ready), 1);
    step();
    bus.i_Ins_Req_Valid = 0;
    serve(0, 1, 32'h6600_AA55, w, a, we, wd, be);
    chk("rm_fresh_addr", a, 32'h600);
    chk("rm_fresh_resp", XLEN'(bus.o_Ins_Resp_Valid), 1);
    step();

    // Stray response while idle
    cnt0 = resp_count;
    bus.i_Mem_Resp_Valid = 1; bus.i_Mem_Resp_Data = 32'h7777_7777;
    step();
    step();
    bus.i_Mem_Resp_Valid = 0;
    @(negedge clk);
    chk("stray_busy", XLEN'(bus.o_Busy), 0);
    chk("stray_req_valid", XLEN'(bus.o_Mem_Req_Valid), 0);
    chk("stray_no_pulse", XLEN'(resp_count - cnt0), 0);
    step();

    chk("sb_drained", XLEN'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
